// File: rtl/xadc_seq_pkg.sv
// Shared constants for the XADC sample sequencer: DRP configuration table,
// channel result addresses and FSM state encodings.
package xadc_seq_pkg;

    localparam int NUM_CFG = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_CFG_WR      = 3'd0;
    localparam state_t ST_CFG_WAIT    = 3'd1;
    localparam state_t ST_IDLE        = 3'd2;
    localparam state_t ST_RD_REQ      = 3'd3;
    localparam state_t ST_RD_WAIT     = 3'd4;
    localparam state_t ST_CFG_RB_REQ  = 3'd5;
    localparam state_t ST_CFG_RB_WAIT = 3'd6;

    // 0x40 config0: 16-sample averaging; 0x41 config1: continuous sequence;
    // 0x49 sequence select: VAUX3 and VAUX11.
    function automatic logic [6:0] cfg_addr(input int idx);
        case (idx)
            0:       return 7'h40;
            1:       return 7'h41;
            2:       return 7'h49;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [15:0] cfg_data(input int idx);
        case (idx)
            0:       return 16'h1000;
            1:       return 16'h2000;
            2:       return 16'h0808;
            default: return 16'h0000;
        endcase
    endfunction

    // Result registers: VP/VN, VAUX3, VAUX11, on-chip temperature.
    function automatic logic [6:0] ch_addr(input int idx);
        case (idx)
            0:       return 7'h03;
            1:       return 7'h13;
            2:       return 7'h1B;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/xadc_sample_sequencer.sv
// Configures the XADC over DRP, then reads NUM_CH result registers per EOC.
// Optional macro XADC_SEQ_READBACK_EN adds a verify read after each config write.
module xadc_sample_sequencer
    import xadc_seq_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int TIMEOUT    = 64,
    parameter int OUT_SIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    output logic        rd_req,
    output logic        wr_en,
    output logic [6:0]  addr,
    output logic [15:0] wr_data,
    input  logic        rd_data_rdy,
    input  logic [15:0] rd_data,
    output logic        sample_valid,
    output logic [1:0]  sample_ch,
    output logic [11:0] sample_data,
    output logic        cfg_done,
    output logic        timeout_err,
    output logic        overrun,
    output logic        cfg_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int IW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] CFG_LAST  = IW'(NUM_CFG - 1);
    localparam logic [1:0]    CH_LAST   = 2'(NUM_CH - 1);
    localparam logic          SIGN_FLIP = (OUT_SIGNED != 0);

    state_t          state;
    logic            armed;
    logic [IW-1:0]   cfg_idx;
    logic [1:0]      ch;
    logic [TW-1:0]   tcount;
    logic            pending;
    logic            in_wait;
    logic            ack;
    logic            expired;
    logic            unused_bits;

    assign unused_bits = ^rd_data[3:0];

`ifdef XADC_SEQ_READBACK_EN
    assign in_wait = (state == ST_CFG_WAIT) || (state == ST_RD_WAIT) ||
                     (state == ST_CFG_RB_WAIT);
`else
    assign in_wait = (state == ST_CFG_WAIT) || (state == ST_RD_WAIT);
`endif
    assign ack     = in_wait && rd_data_rdy;
    assign expired = in_wait && !rd_data_rdy && (tcount == T_LAST);

    // Requests decode straight from state so each lasts exactly one cycle;
    // armed holds them off for the first cycle after reset.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        rd_req  = 1'b0;
        wr_en   = 1'b0;
        addr    = 7'h00;
        wr_data = 16'h0000;
        if (armed) begin
            case (state)
                ST_CFG_WR: begin
                    wr_en   = 1'b1;
                    addr    = cfg_addr(int'(cfg_idx));
                    wr_data = cfg_data(int'(cfg_idx));
                end
                ST_RD_REQ: begin
                    rd_req = 1'b1;
                    addr   = ch_addr(int'(ch));
                end
`ifdef XADC_SEQ_READBACK_EN
                ST_CFG_RB_REQ: begin
                    rd_req = 1'b1;
                    addr   = cfg_addr(int'(cfg_idx));
                end
`endif
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_CFG_WR;
            armed        <= 1'b0;
            cfg_idx      <= '0;
            ch           <= 2'd0;
            tcount       <= '0;
            pending      <= 1'b0;
            cfg_done     <= 1'b0;
            timeout_err  <= 1'b0;
            overrun      <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= 2'd0;
            sample_data  <= 12'h000;
`ifdef XADC_SEQ_READBACK_EN
            cfg_err      <= 1'b0;
`endif
        end else begin
            armed        <= 1'b1;
            sample_valid <= 1'b0;
            if (in_wait)
                tcount <= tcount + 1'b1;
            if (expired)
                timeout_err <= 1'b1;

            // IDLE consumes eoc itself; elsewhere it is queued one deep.
            if (eoc && state != ST_IDLE) begin
                if (pending)
                    overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end

            case (state)
                ST_CFG_WR: begin
                    if (armed) begin
                        state  <= ST_CFG_WAIT;
                        tcount <= '0;
                    end
                end
                ST_CFG_WAIT: begin
                    if (ack || expired) begin
`ifdef XADC_SEQ_READBACK_EN
                        state <= ST_CFG_RB_REQ;
`else
                        if (cfg_idx == CFG_LAST) begin
                            cfg_done <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            cfg_idx <= cfg_idx + 1'b1;
                            state   <= ST_CFG_WR;
                        end
`endif
                    end
                end
`ifdef XADC_SEQ_READBACK_EN
                ST_CFG_RB_REQ: begin
                    state  <= ST_CFG_RB_WAIT;
                    tcount <= '0;
                end
                ST_CFG_RB_WAIT: begin
                    if (ack || expired) begin
                        if (ack && rd_data != cfg_data(int'(cfg_idx)))
                            cfg_err <= 1'b1;
                        if (cfg_idx == CFG_LAST) begin
                            cfg_done <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            cfg_idx <= cfg_idx + 1'b1;
                            state   <= ST_CFG_WR;
                        end
                    end
                end
`endif
                ST_IDLE: begin
                    if (eoc || pending) begin
                        pending <= 1'b0;
                        ch      <= 2'd0;
                        state   <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    state  <= ST_RD_WAIT;
                    tcount <= '0;
                end
                ST_RD_WAIT: begin
                    if (ack || expired) begin
                        if (ack) begin
                            sample_valid <= 1'b1;
                            sample_ch    <= ch;
                            sample_data  <= {rd_data[15] ^ SIGN_FLIP, rd_data[14:4]};
                        end
                        if (ch == CH_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= ST_RD_REQ;
                        end
                    end
                end
                default: state <= ST_CFG_WR;
            endcase
        end
    end

`ifndef XADC_SEQ_READBACK_EN
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_xadc_sample_sequencer.sv
// Directed bench for xadc_sample_sequencer with a behavioural DRP transceiver
// model (fixed 4-cycle ack latency); build with XADC_SEQ_READBACK_EN to cover readback.
module tb_xadc_sample_sequencer;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eoc = 1'b0;
    logic        rd_data_rdy = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        rd_req, wr_en;
    logic [6:0]  addr;
    logic [15:0] wr_data;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [11:0] sample_data;
    logic        cfg_done, timeout_err, overrun, cfg_err;

    xadc_sample_sequencer #(.NUM_CH(2), .TIMEOUT(64), .OUT_SIGNED(1)) dut (
        .clk(clk), .rst(rst), .eoc(eoc),
        .rd_req(rd_req), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
        .rd_data_rdy(rd_data_rdy), .rd_data(rd_data),
        .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
        .cfg_done(cfg_done), .timeout_err(timeout_err), .overrun(overrun), .cfg_err(cfg_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [6:0] addr; logic [15:0] data; int cyc; } drp_ev_t;
    typedef struct { logic [1:0] ch; logic [11:0] data; int delta; } samp_t;
    typedef struct { logic [15:0] rd0; logic [15:0] rd1; logic [11:0] exp0; logic [11:0] exp1; } vec_t;

    drp_ev_t     wr_q[$];
    drp_ev_t     rd_q[$];
    samp_t       samp_q[$];
    logic [15:0] resp_q[$];
    vec_t        vecs[4];

    logic [6:0]  exp_cfg_addr[3] = '{7'h40, 7'h41, 7'h49};
    logic [15:0] exp_cfg_data[3] = '{16'h1000, 16'h2000, 16'h0808};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int viol = 0;
    int early_rd = 0;
    int last_ack_cyc = 0;
    int cfg_done_cyc = 0;
    int drop = 0;
    bit cancel = 0;
    bit inject_stale = 0;
    bit corrupt_41 = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycle %0d, limit 20000", cyc);
            $fatal(1, "watchdog");
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_cfg_addr(input logic [6:0] a);
        return (a == 7'h40) || (a == 7'h41) || (a == 7'h49);
    endfunction

    // Monitor first, then the DRP model, in one process so their order is fixed.
    initial begin
        int cnt = 0;
        logic [15:0] resp = 16'h0;
        logic prev_wr = 1'b0, prev_rd = 1'b0, prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_req && wr_en) viol++;
            if (!rd_req && !wr_en && (addr != 7'h00 || wr_data != 16'h0000)) viol++;
            if (rd_req && wr_data != 16'h0000) viol++;
            if ((wr_en && prev_wr) || (rd_req && prev_rd)) viol++;
            if (wr_en) wr_q.push_back('{addr, wr_data, cyc});
            if (rd_req) begin
                rd_q.push_back('{addr, 16'h0000, cyc});
                if (!cfg_done && !is_cfg_addr(addr)) early_rd++;
            end
            if (sample_valid) samp_q.push_back('{sample_ch, sample_data, cyc - last_ack_cyc});
            if (cfg_done && !prev_done) cfg_done_cyc = cyc;
            prev_wr = wr_en;
            prev_rd = rd_req;
            prev_done = cfg_done;

            rd_data_rdy = 1'b0;
            rd_data = 16'h0000;
            if (cancel) begin
                cnt = 0;
                cancel = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    rd_data_rdy = 1'b1;
                    rd_data = resp;
                    last_ack_cyc = cyc;
                end
            end
            if (inject_stale) begin
                rd_data_rdy = 1'b1;
                rd_data = 16'hDEAD;
                inject_stale = 0;
            end
            if ((rd_req || wr_en) && !rst) begin
                if (cnt != 0) viol++;
                if (rd_req && drop > 0) begin
                    drop--;
                end else begin
                    cnt = LAT;
                    if (wr_en) resp = 16'h0000;
                    else if (is_cfg_addr(addr)) begin
                        resp = 16'h0000;
                        for (int i = 0; i < 3; i++)
                            if (exp_cfg_addr[i] == addr) resp = exp_cfg_data[i];
                        if (corrupt_41 && addr == 7'h41) resp = 16'h0000;
                    end else if (resp_q.size() > 0) resp = resp_q.pop_front();
                    else resp = 16'h0000;
                end
            end
        end
    end

    task automatic pulse_eoc();
        @(negedge clk) eoc = 1'b1;
        @(negedge clk) eoc = 1'b0;
    endtask

    task automatic wait_cfg_done(input int budget);
        int n = 0;
        while (!cfg_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("cfg_done_within_budget", 64'(cfg_done), 64'd1);
    endtask

    task automatic wait_samples(input int want, input int budget);
        int n = 0;
        while (samp_q.size() < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sample_count_within_budget", 64'(samp_q.size()), 64'(want));
    endtask

    function automatic logic [63:0] all_outputs();
        return {20'h0, rd_req, wr_en, addr, wr_data, sample_valid, sample_ch,
                sample_data, cfg_done, timeout_err, overrun, cfg_err};
    endfunction

    initial begin
        int n;
`ifdef XADC_SEQ_READBACK_EN
        int cfg_span = 30;
`else
        int cfg_span = 15;
`endif
        // rd0/rd1 -> rd_data[15:4] with MSB inverted
        vecs[0] = '{16'h8000, 16'h4010, 12'h000, 12'hC01};
        vecs[1] = '{16'hFFF0, 16'h0000, 12'h7FF, 12'h800};
        vecs[2] = '{16'h7FFF, 16'h800F, 12'hFFF, 12'h000};
        vecs[3] = '{16'h1234, 16'hABCD, 12'h923, 12'h2BC};

        // Reset and configuration
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 64'h0);
        rst = 1'b0;
        wait_cfg_done(300);
        check("cfg_wr_count", 64'(wr_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < wr_q.size()) begin
                check($sformatf("cfg_addr[%0d]", i), 64'(wr_q[i].addr), 64'(exp_cfg_addr[i]));
                check($sformatf("cfg_data[%0d]", i), 64'(wr_q[i].data), 64'(exp_cfg_data[i]));
            end
        end
        check("cfg_done_after_last_ack", 64'(cfg_done_cyc - last_ack_cyc), 64'd1);
        check("no_rd_before_cfg_done", 64'(early_rd), 64'd0);
        repeat (5) @(negedge clk);

        // Table-driven bursts
        for (int v = 0; v < 4; v++) begin
            samp_q.delete();
            rd_q.delete();
            resp_q.push_back(vecs[v].rd0);
            resp_q.push_back(vecs[v].rd1);
            pulse_eoc();
            wait_samples(2, 100);
            if (samp_q.size() >= 2 && rd_q.size() >= 2) begin
                check($sformatf("v%0d_ch0", v), 64'(samp_q[0].ch), 64'd0);
                check($sformatf("v%0d_data0", v), 64'(samp_q[0].data), 64'(vecs[v].exp0));
                check($sformatf("v%0d_lat0", v), 64'(samp_q[0].delta), 64'd1);
                check($sformatf("v%0d_ch1", v), 64'(samp_q[1].ch), 64'd1);
                check($sformatf("v%0d_data1", v), 64'(samp_q[1].data), 64'(vecs[v].exp1));
                check($sformatf("v%0d_lat1", v), 64'(samp_q[1].delta), 64'd1);
                check($sformatf("v%0d_addr0", v), 64'(rd_q[0].addr), 64'h03);
                check($sformatf("v%0d_addr1", v), 64'(rd_q[1].addr), 64'h13);
            end
            repeat (5) @(negedge clk);
        end

        // Channel 0 read never acknowledged
        check("timeout_err_clear", 64'(timeout_err), 64'd0);
        samp_q.delete();
        rd_q.delete();
        drop = 1;
        resp_q.push_back(16'h4010);
        pulse_eoc();
        wait_samples(1, 300);
        repeat (20) @(negedge clk);
        check("timeout_sample_count", 64'(samp_q.size()), 64'd1);
        if (samp_q.size() >= 1) begin
            check("timeout_sample_ch", 64'(samp_q[0].ch), 64'd1);
            check("timeout_sample_data", 64'(samp_q[0].data), 64'hC01);
        end
        check("timeout_rd_count", 64'(rd_q.size()), 64'd2);
        // Wait starts the cycle after the ch0 request; ch1 request 64 cycles later.
        if (rd_q.size() >= 2)
            check("timeout_ch1_req_gap", 64'(rd_q[1].cyc - rd_q[0].cyc), 64'd65);
        check("timeout_err_set", 64'(timeout_err), 64'd1);

        // Three extra EOCs during one burst
        check("overrun_clear", 64'(overrun), 64'd0);
        samp_q.delete();
        rd_q.delete();
        for (int i = 0; i < 4; i++) resp_q.push_back(16'h1000 + 16'(i * 16));
        pulse_eoc();
        pulse_eoc();
        pulse_eoc();
        pulse_eoc();
        repeat (100) @(negedge clk);
        check("overrun_set", 64'(overrun), 64'd1);
        check("overrun_sample_count", 64'(samp_q.size()), 64'd4);
        check("overrun_rd_count", 64'(rd_q.size()), 64'd4);

        // Reset while a read is outstanding
        resp_q.delete();
        resp_q.push_back(16'h1110);
        samp_q.delete();
        pulse_eoc();
        n = 0;
        while (!rd_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_rd_req_seen", 64'(rd_req), 64'd1);
        @(negedge clk);
        wr_q.delete();
        rst = 1'b1;
        cancel = 1;
        @(negedge clk);
        check("mid_reset_outputs", all_outputs(), 64'h0);
        rst = 1'b0;
        inject_stale = 1;
        wait_cfg_done(300);
        check("mid_cfg_wr_count", 64'(wr_q.size()), 64'd3);
        if (wr_q.size() >= 1) begin
            check("mid_cfg_first_addr", 64'(wr_q[0].addr), 64'h40);
            check("mid_cfg_span", 64'(cfg_done_cyc - wr_q[0].cyc), 64'(cfg_span));
        end
        check("mid_no_sample", 64'(samp_q.size()), 64'd0);
        resp_q.delete();

`ifdef XADC_SEQ_READBACK_EN
        corrupt_41 = 1;
        @(negedge clk);
        rst = 1'b1;
        cancel = 1;
        @(negedge clk);
        rst = 1'b0;
        wait_cfg_done(400);
        check("readback_cfg_err", 64'(cfg_err), 64'd1);
        check("readback_cfg_done", 64'(cfg_done), 64'd1);
`else
        check("cfg_err_tied_low", 64'(cfg_err), 64'd0);
`endif

        repeat (5) @(negedge clk);
        check("protocol_violations", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xadc_sample_sequencer.md
Name: xadc_sample_sequencer

Overview:
- Control stage directly upstream of the DRP transceiver; drives its rd_req/wr_en/addr/wr_data and consumes its rd_data_rdy/rd_data.
- After reset, writes a fixed XADC configuration table over DRP.
- Then, on each XADC end-of-conversion pulse, reads NUM_CH channel result registers in order.
- Emits one 12-bit sample per channel to the noise filter datapath.

Parameters:
- NUM_CH, 2: channels read per EOC, 1..4; addresses from CH_ADDR[0..NUM_CH-1].
- TIMEOUT, 64: cycles to wait for rd_data_rdy after a request before abandoning it.
- OUT_SIGNED, 1: 1 = flip the code MSB (offset binary to two's complement); 0 = raw unsigned code.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- eoc  in  1  XADC end-of-conversion, single-cycle pulse
- rd_req  out  1  DRP read request to transceiver
- wr_en  out  1  DRP write enable to transceiver
- addr  out  7  DRP address
- wr_data  out  16  DRP write data
- rd_data_rdy  in  1  DRP transaction done; ack for both reads and writes
- rd_data  in  16  DRP read data, valid with rd_data_rdy
- sample_valid  out  1  one-cycle strobe
- sample_ch  out  2  channel index of sample
- sample_data  out  12  sample value
- cfg_done  out  1  configuration table complete
- timeout_err  out  1  sticky: a DRP transaction timed out
- overrun  out  1  sticky: an EOC was lost
- cfg_err  out  1  sticky readback mismatch; tied 0 without the optional feature

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: every output 0; FSM to CFG_WR with table index 0; counters, pending flag and sticky flags cleared.
- Reset mid-transaction: abandon the transaction and restart configuration from entry 0.
- FSM states: CFG_WR, CFG_WAIT, IDLE, RD_REQ, RD_WAIT.
- CFG_WR:
  - Assert wr_en for exactly 1 cycle with addr = CFG_ADDR[i] and wr_data = CFG_DATA[i].
  - Go to CFG_WAIT.
- CFG_WAIT, on rd_data_rdy or timeout:
  - Timeout sets timeout_err.
  - If i = NUM_CFG-1: set cfg_done (held until reset) and go to IDLE.
  - Otherwise i++ and go to CFG_WR.
- IDLE: on eoc or pending set, clear pending, set ch = 0, go to RD_REQ.
- RD_REQ: assert rd_req for exactly 1 cycle with addr = CH_ADDR[ch]; go to RD_WAIT.
- RD_WAIT, on rd_data_rdy:
  - Register output next cycle: sample_valid = 1, sample_ch = ch.
  - sample_data = rd_data[15:4], MSB inverted if OUT_SIGNED.
- RD_WAIT, on timeout: set timeout_err; no sample is emitted for that channel.
- RD_WAIT exit (either case): ch++; go to RD_REQ if ch < NUM_CH, else IDLE.
- Timeout counter:
  - Reset on entering a WAIT state.
  - Timeout fires when the counter reaches TIMEOUT-1 with no rd_data_rdy.
  - rd_data_rdy on that same cycle wins; it is not a timeout.
- Latency: at least 3 cycles from request to ack, because the transceiver registers both directions.
  - Sample output is exactly 1 cycle after rd_data_rdy.
- EOC during configuration or a read burst:
  - Set pending, one deep.
  - If pending is already set: overrun = 1 (sticky); the extra EOC is dropped.
  - EOC in the same cycle the FSM leaves IDLE is consumed and does not set pending.
- rd_data_rdy outside a WAIT state is ignored.
- Never more than one DRP transaction outstanding.
- rd_req and wr_en are never high together.
- addr and wr_data are 0 whenever no request is driven.

Optional Feature:
- Macro: XADC_SEQ_READBACK_EN.
- Defined:
  - Each configuration write is followed by a read of the same address (states CFG_RB_REQ, CFG_RB_WAIT).
  - A mismatch against CFG_DATA[i] sets cfg_err (sticky); configuration still proceeds.
  - cfg_done rises after the last readback.
- Undefined: no readback states; cfg_err tied 0.

Decomposition:
- Package xadc_seq_pkg holds:
  - NUM_CFG, CFG_ADDR/CFG_DATA table (0x40 config0 averaging, 0x41 config1 continuous sequence, 0x49 channel select).
  - CH_ADDR table (0x03 VP/VN, 0x13 VAUX3, 0x1B VAUX11, 0x00 temperature).
  - FSM state enum.
- No sub-module; a single FSM plus timeout counter is sufficient.

Test Plan:
- Reset release, DRP model acks after 4 cycles:
  - Exactly NUM_CFG single-cycle wr_en pulses with table addr/data.
  - cfg_done high after the last ack; no rd_req before it.
- cfg_done = 1, eoc pulse, model returns 0x8000 then 0x4010 (OUT_SIGNED = 1):
  - samples (ch 0, 0x000) then (ch 1, 0xC01).
  - Each sample_valid is 1 cycle after its rd_data_rdy.
- Model never acks the ch 0 read, TIMEOUT = 64:
  - rd_req for ch 1 is issued 64 cycles after the ch 0 wait begins.
  - timeout_err = 1; only the ch 1 sample is emitted.
- Three eoc pulses during one read burst: overrun = 1; exactly one additional burst follows.
- Assert rst for 1 cycle in RD_WAIT:
  - All outputs 0 the next cycle; configuration restarts at entry 0.
  - A stale rd_data_rdy is ignored.
- XADC_SEQ_READBACK_EN, model returns 0x0000 for the 0x41 readback: cfg_err = 1; cfg_done still rises.
